// File: rtl/sipo_scan_ctrl.sv
// Scan sequencer for a 74HC165 serial-input reader chain.
// Windows acquisition, debounces each bit, raises sticky edge flags and irq.
module sipo_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEB_FRAMES = 3,
  parameter int TIMEOUT = 1024,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             ena,
  input  logic [15:0]      scan_period,
  output logic             sipo_sync,
  input  logic [WIDTH-1:0] sipo_data,
  input  logic             sipo_valid,
  output logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] inputs,
  output logic [WIDTH-1:0] rise_flags,
  output logic [WIDTH-1:0] fall_flags,
  input  logic [WIDTH-1:0] clr_rise,
  input  logic [WIDTH-1:0] clr_fall,
  input  logic [WIDTH-1:0] irq_mask,
  output logic             irq,
  output logic [15:0]      frame_cnt,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_ACQ = 2'd1;
  localparam logic [1:0] S_GAP = 2'd2;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0] D_LAST = 4'(DEB_FRAMES - 1);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [TW-1:0]    timer;
  logic [15:0]      gap;
  logic [3:0]       deb [WIDTH];
  logic             in_acq;
  logic             accept;
  logic             tmo;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;

  assign in_acq = ena && (state == S_ACQ);
  assign accept = in_acq && sipo_valid;
  assign tmo    = in_acq && !sipo_valid && (timer == T_LAST);

  always_comb begin
    state_n = state;
    if (!ena) begin
      state_n = S_OFF;
    end else begin
      case (state)
        S_OFF: state_n = S_ACQ;
        S_ACQ: if (accept || tmo) state_n = S_GAP;
        S_GAP: if (gap <= 16'd1) state_n = S_ACQ;
        default: state_n = S_OFF;
      endcase
    end
  end

  // a zero-length gap still spends one clock in GAP so sync pulses
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state     <= S_OFF;
      sipo_sync <= 1'b1;
      timer     <= '0;
      gap       <= '0;
    end else begin
      state     <= state_n;
      sipo_sync <= (state_n != S_ACQ);
      if (state_n == S_ACQ && state != S_ACQ)
        timer <= '0;
      else if (state == S_ACQ)
        timer <= timer + 1'b1;
      if (state_n == S_GAP && state != S_GAP)
        gap <= scan_period;
      else if (state == S_GAP && gap != 16'd0)
        gap <= gap - 16'd1;
    end
  end

  always_comb begin
    tog = '0;
    for (int i = 0; i < WIDTH; i++)
      tog[i] = accept && (sipo_data[i] != inputs[i]) && (deb[i] == D_LAST);
  end

  assign rise_set = tog & ~inputs;
  assign fall_set = tog & inputs;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      raw       <= '0;
      inputs    <= INIT;
      frame_cnt <= '0;
      for (int i = 0; i < WIDTH; i++) deb[i] <= '0;
    end else if (accept) begin
      raw       <= sipo_data;
      inputs    <= inputs ^ tog;
      frame_cnt <= frame_cnt + 16'd1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sipo_data[i] == inputs[i] || tog[i])
          deb[i] <= '0;
        else
          deb[i] <= deb[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rise_flags  <= '0;
      fall_flags  <= '0;
      irq         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rise_flags  <= (rise_flags & ~clr_rise) | rise_set;
      fall_flags  <= (fall_flags & ~clr_fall) | fall_set;
      irq         <= |((rise_flags | fall_flags) & irq_mask);
      timeout_err <= (timeout_err & ~err_clr) | tmo;
    end
  end

endmodule
